// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 set-2 scancode parser tracking held state of mapped keys
// Emits registered press/release pulses, last completed code and a malformed/timeout error strobe.
module ps2_key_tracker #(
    parameter int                    NUM_KEYS       = 4,
    parameter logic [9*NUM_KEYS-1:0] KEY_MAP        = {9'h172, 9'h175, 9'h05A, 9'h029},
    parameter int                    TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                code_valid,
    input  logic [7:0]          code_in,
    input  logic                flush,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic                any_key,
    output logic [8:0]          last_code,
    output logic                code_err
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 2);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXT     = 2'd1;
    localparam logic [1:0] S_BRK     = 2'd2;
    localparam logic [1:0] S_EXT_BRK = 2'd3;

    logic [1:0]          r_state;
    logic [CW-1:0]       r_cnt;
    logic [NUM_KEYS-1:0] r_key_down;
    logic [NUM_KEYS-1:0] r_press;
    logic [NUM_KEYS-1:0] r_release;
    logic                r_any;
    logic [8:0]          r_last;
    logic                r_err;

    logic [1:0]          w_state_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic                w_err;
    logic                w_done;
    logic                w_brk;
    logic [8:0]          w_code9;
    logic                w_ignored;
    logic                w_is_e0;
    logic                w_is_f0;
    logic [NUM_KEYS-1:0] w_kd_nxt;
    logic [NUM_KEYS-1:0] w_press;
    logic [NUM_KEYS-1:0] w_release;

    assign w_is_e0   = (code_in == 8'hE0);
    assign w_is_f0   = (code_in == 8'hF0);
    // Keyboard status replies and the Pause lead-in never form a make in IDLE
    assign w_ignored = (code_in == 8'hAA) || (code_in == 8'hFA) || (code_in == 8'hEE) ||
                       (code_in == 8'hFE) || (code_in == 8'h00) || (code_in == 8'hFF) ||
                       (code_in == 8'hE1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err       = 1'b0;
        w_done      = 1'b0;
        w_brk       = 1'b0;
        w_code9     = {1'b0, code_in};
        if (code_valid) begin
            w_cnt_nxt = '0;
            case (r_state)
                S_IDLE: begin
                    if (w_is_e0)        w_state_nxt = S_EXT;
                    else if (w_is_f0)   w_state_nxt = S_BRK;
                    else if (!w_ignored) w_done     = 1'b1;
                end
                S_EXT: begin
                    if (w_is_f0) begin
                        w_state_nxt = S_EXT_BRK;
                    end else if (w_is_e0) begin
                        w_err = 1'b1;
                    end else begin
                        w_done      = 1'b1;
                        w_code9     = {1'b1, code_in};
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    w_state_nxt = S_IDLE;
                    if (w_is_e0 || w_is_f0) begin
                        w_err = 1'b1;
                    end else begin
                        w_done  = 1'b1;
                        w_brk   = 1'b1;
                        w_code9 = {(r_state == S_EXT_BRK), code_in};
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (r_state != S_IDLE) begin
            if (r_cnt == CNT_LAST) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_err       = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    // Every map entry is compared so duplicate entries all track the same physical key
    always_comb begin
        w_kd_nxt  = r_key_down;
        w_press   = '0;
        w_release = '0;
        if (w_done) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (KEY_MAP[9*i +: 9] == w_code9) begin
                    if (!w_brk && !r_key_down[i]) begin
                        w_kd_nxt[i] = 1'b1;
                        w_press[i]  = 1'b1;
                    end else if (w_brk && r_key_down[i]) begin
                        w_kd_nxt[i]  = 1'b0;
                        w_release[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_key_down <= '0;
            r_press    <= '0;
            r_release  <= '0;
            r_any      <= 1'b0;
            r_last     <= '0;
            r_err      <= 1'b0;
        end else if (flush) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_key_down <= '0;
            r_press    <= '0;
            r_release  <= '0;
            r_any      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_key_down <= w_kd_nxt;
            r_press    <= w_press;
            r_release  <= w_release;
            r_any      <= |w_kd_nxt;
            r_err      <= w_err;
            if (w_done) r_last <= w_code9;
        end
    end

    assign key_down      = r_key_down;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign any_key       = r_any;
    assign last_code     = r_last;
    assign code_err      = r_err;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - bench for ps2_key_tracker: directed literals plus random traffic vs model
module tb_ps2_key_tracker;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       code_valid = 1'b0;
    logic [7:0] code_in = 8'h00;
    logic       flush = 1'b0;
    logic [3:0] key_down, press_pulse, release_pulse;
    logic       any_key, code_err;
    logic [8:0] last_code;

    logic [8:0] key_tab [4] = '{9'h029, 9'h05A, 9'h175, 9'h172};

    ps2_key_tracker #(
        .NUM_KEYS(4),
        .KEY_MAP({9'h172, 9'h175, 9'h05A, 9'h029}),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .reset(rst_n), .code_valid(code_valid), .code_in(code_in), .flush(flush),
        .key_down(key_down), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .any_key(any_key), .last_code(last_code), .code_err(code_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: a pending prefix is remembered as flags; sequences complete into make/break events
    bit [3:0] m_kd, m_pp, m_rp;
    bit       m_any, m_err, m_pend, m_ext, m_brk;
    bit [8:0] m_last;
    int       m_idle;

    task complete(input bit ext, input bit [7:0] b, input bit brk);
        m_last = {ext, b};
        m_pend = 0; m_ext = 0; m_brk = 0;
        for (int i = 0; i < 4; i++) begin
            if (key_tab[i] == {ext, b}) begin
                if (!brk && !m_kd[i]) begin m_kd[i] = 1; m_pp[i] = 1; end
                if (brk && m_kd[i])   begin m_kd[i] = 0; m_rp[i] = 1; end
            end
        end
    endtask

    task handle_byte(input bit [7:0] b);
        if (!m_pend) begin
            if (b == 8'hE0) begin m_pend = 1; m_ext = 1; end
            else if (b == 8'hF0) begin m_pend = 1; m_brk = 1; end
            else if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1})) complete(0, b, 0);
        end else if (!m_brk) begin
            if (b == 8'hF0) m_brk = 1;
            else if (b == 8'hE0) m_err = 1;
            else complete(1, b, 0);
        end else begin
            if (b == 8'hE0 || b == 8'hF0) begin
                m_err = 1; m_pend = 0; m_ext = 0; m_brk = 0;
            end else complete(m_ext, b, 1);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_kd = 0; m_pp = 0; m_rp = 0; m_any = 0; m_err = 0; m_last = 0;
            m_pend = 0; m_ext = 0; m_brk = 0; m_idle = 0;
        end else begin
            m_pp = 0; m_rp = 0; m_err = 0;
            if (flush) begin
                m_pend = 0; m_ext = 0; m_brk = 0; m_kd = 0; m_idle = 0;
            end else if (code_valid) begin
                m_idle = 0;
                handle_byte(code_in);
            end else if (m_pend) begin
                m_idle++;
                if (m_idle == T - 1) begin
                    m_err = 1; m_pend = 0; m_ext = 0; m_brk = 0; m_idle = 0;
                end
            end
            m_any = |m_kd;
        end
    end

    always @(negedge clk) begin
        n_cmp++;
        if ({key_down, press_pulse, release_pulse, any_key, last_code, code_err} !==
            {m_kd, m_pp, m_rp, m_any, m_last, m_err}) begin
            n_bad++;
            $display("FAIL model_cycle t=%0t got kd=%h pp=%h rp=%h any=%b last=%h err=%b exp kd=%h pp=%h rp=%h any=%b last=%h err=%b",
                     $time, key_down, press_pulse, release_pulse, any_key, last_code, code_err,
                     m_kd, m_pp, m_rp, m_any, m_last, m_err);
        end
    end

    task chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task send(input logic [7:0] b);
        @(negedge clk);
        code_valid = 1'b1;
        code_in    = b;
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {key_down, press_pulse, release_pulse, any_key, last_code, code_err}, 0);
        rst_n = 1'b1;

        send(8'h29);
        chk("make29_press", press_pulse, 4'b0001);
        chk("make29_down", key_down, 4'b0001);
        chk("make29_last", last_code, 9'h029);
        chk("make29_any", any_key, 1'b1);
        send(8'hF0); send(8'h29);
        chk("brk29_release", release_pulse, 4'b0001);
        chk("brk29_down", key_down, 4'b0000);

        send(8'hE0); send(8'h75);
        chk("up_first_press", press_pulse, 4'b0100);
        send(8'hE0); send(8'h75);
        chk("up_repeat_nopulse", press_pulse, 4'b0000);
        send(8'hE0); send(8'h75);
        chk("up_repeat_down", key_down, 4'b0100);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("up_release", release_pulse, 4'b0100);
        chk("up_release_down", key_down, 4'b0000);

        send(8'h75);
        chk("kp8_down", key_down, 4'b0000);
        chk("kp8_last", last_code, 9'h075);
        chk("kp8_nopulse", press_pulse, 4'b0000);

        send(8'hF0);
        repeat (14) @(negedge clk);
        chk("timeout_early", code_err, 1'b0);
        @(negedge clk);
        chk("timeout_err", code_err, 1'b1);
        send(8'h29);
        chk("after_timeout_make", press_pulse, 4'b0001);

        send(8'h5A);
        chk("held_two", key_down, 4'b0011);
        @(negedge clk);
        flush = 1'b1; code_valid = 1'b1; code_in = 8'hF0;
        @(negedge clk);
        flush = 1'b0; code_valid = 1'b0;
        chk("flush_down", key_down, 4'b0000);
        chk("flush_norelease", release_pulse, 4'b0000);
        send(8'h5A);
        chk("flush_then_make", press_pulse, 4'b0010);

        send(8'hF0); send(8'hF0);
        chk("f0f0_err", code_err, 1'b1);
        send(8'hE0); send(8'hE0);
        chk("e0e0_err", code_err, 1'b1);
        send(8'h72);
        chk("e0e0_72_press", press_pulse, 4'b1000);

        send(8'hE0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_e0", {key_down, press_pulse, release_pulse, any_key, last_code, code_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            flush = ($urandom_range(0, 79) == 0);
            if (n == 2000) rst_n = 1'b0;
            if (n == 2003) rst_n = 1'b1;
            if ($urandom_range(0, 99) < 3) begin
                code_valid = 1'b0;
                repeat ($urandom_range(5, 20)) @(negedge clk);
            end
            code_valid = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 9))
                0, 1:    code_in = 8'hE0;
                2, 3:    code_in = 8'hF0;
                4:       code_in = 8'h29;
                5:       code_in = 8'h5A;
                6:       code_in = 8'h75;
                7:       code_in = 8'h72;
                8:       code_in = 8'hAA;
                default: code_in = 8'($urandom);
            endcase
        end
        @(negedge clk);
        code_valid = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
